rpn_stack_ctrl: RTL and testbench

- Operand-stack controller for the RPN calculator.
- Sits directly upstream of the registered-read dual-port RAM: drives its read address, write address, write enable and write data, and consumes its data output.
- Caches top-of-stack (TOS) and next-of-stack (NOS) in registers so the ALU sees both operands combinationally. Deeper entries spill to and refill from the RAM.
- Accepts PUSH / POP / REPLACE2 commands over a valid/ready handshake.

---
 rtl/rpn_stack_ctrl.sv | 156 +++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl.sv
// Operand-stack controller for the RPN calculator: caches TOS/NOS in registers and spills
// deeper entries to a registered-read dual-port RAM, refilling NOS after POP/REPLACE2.
module rpn_stack_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    output logic [DATA_WIDTH-1:0]   tos,
    output logic [DATA_WIDTH-1:0]   nos,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic                    err_overflow,
    output logic                    err_underflow,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int unsigned CntW = ADDR_WIDTH + 2;
    localparam logic [CntW-1:0] Cap   = CntW'(2 ** ADDR_WIDTH + 2);
    localparam logic [CntW-1:0] One   = CntW'(1);
    localparam logic [CntW-1:0] Two   = CntW'(2);
    localparam logic [CntW-1:0] Three = CntW'(3);

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpPush = 2'b01;
    localparam logic [1:0] OpPop  = 2'b10;
    localparam logic [1:0] OpRep2 = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait1,
        StWait2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tos_q, tos_d;
    logic [DATA_WIDTH-1:0]   nos_q, nos_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic [CntW-1:0]         sp;
    logic                    is_full;

    // Number of entries currently spilled to RAM.
    assign sp      = (count_q >= Two) ? (count_q - Two) : '0;
    assign is_full = (count_q == Cap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tos_q     <= '0;
            nos_q     <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tos_q     <= tos_d;
            nos_q     <= nos_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tos_d     = tos_q;
        nos_d     = nos_q;
        count_d   = count_q;
        rd_addr_d = rd_addr_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OpNop: ;
                        OpPush: begin
                            if (is_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                nos_d   = tos_q;
                                tos_d   = cmd_data;
                                count_d = count_q + One;
                            end
                        end
                        OpPop: begin
                            if (count_q == '0) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d   = nos_q;
                                count_d = count_q - One;
                                if (count_q >= Three) begin
                                    rd_addr_d = ADDR_WIDTH'(sp - One);
                                    state_d   = StWait1;
                                end else begin
                                    nos_d = '0;
                                end
                            end
                        end
                        OpRep2: begin
                            if (count_q < Two) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d   = cmd_data;
                                count_d = count_q - One;
                                if (count_q >= Three) begin
                                    rd_addr_d = ADDR_WIDTH'(sp - One);
                                    state_d   = StWait1;
                                end else begin
                                    nos_d = '0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // RAM registers the read address during this cycle.
            StWait1: state_d = StWait2;
            StWait2: begin
                nos_d   = ram_rdata;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready   = (state_q == StIdle);
        ram_we      = cmd_ready && cmd_valid && (cmd_op == OpPush) && !is_full
                      && (count_q >= Two);
        ram_wr_addr = sp[ADDR_WIDTH-1:0];
        ram_wdata   = nos_q;
    end

    assign tos           = tos_q;
    assign nos           = nos_q;
    assign count         = count_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign ram_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: queue-based stack model checked every cycle, a registered-read
// RAM model, and directed sequences with literal expectations.
module tb_rpn_stack_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int CAP = 6;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] REP2 = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [AW+1:0] count;
    logic          err_overflow;
    logic          err_underflow;
    logic [AW-1:0] ram_rd_addr;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    rpn_stack_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .tos          (tos),
        .nos          (nos),
        .count        (count),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow),
        .ram_rd_addr  (ram_rd_addr),
        .ram_wr_addr  (ram_wr_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read dual-port RAM.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wdata;
        ram_rdata <= mem[ram_rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack model: index 0 is the top.
    logic [DW-1:0] mq[$];
    int m_stall = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    always @(posedge clk) begin
        m_ovf = 0;
        m_unf = 0;
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else if (m_stall > 0) begin
            m_stall--;
        end else if (cmd_valid) begin
            case (cmd_op)
                PUSH: if (mq.size() == CAP) m_ovf = 1; else mq.push_front(cmd_data);
                POP: begin
                    if (mq.size() == 0) m_unf = 1;
                    else begin
                        if (mq.size() >= 3) m_stall = 2;
                        void'(mq.pop_front());
                    end
                end
                REP2: begin
                    if (mq.size() < 2) m_unf = 1;
                    else begin
                        if (mq.size() >= 3) m_stall = 2;
                        void'(mq.pop_front());
                        void'(mq.pop_front());
                        mq.push_front(cmd_data);
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int  sz;
            bit  rdy;
            bit  exp_we;
            sz  = mq.size();
            rdy = (m_stall == 0);
            chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
            chk("count", 32'(count), 32'(sz));
            chk("tos", 32'(tos), (sz > 0) ? 32'(mq[0]) : 32'd0);
            if (rdy) chk("nos", 32'(nos), (sz > 1) ? 32'(mq[1]) : 32'd0);
            chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
            chk("err_underflow", 32'(err_underflow), 32'(m_unf));
            exp_we = rdy && cmd_valid && (cmd_op == PUSH) && sz >= 2 && sz < CAP;
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_we) begin
                chk("ram_wr_addr", 32'(ram_wr_addr), 32'(sz - 2));
                chk("ram_wdata", 32'(ram_wdata), 32'(mq[1]));
            end
            for (int k = 0; k < sz - 2; k++) chk("ram_slot", 32'(mem[k]), 32'(mq[sz-1-k]));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] d);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [DW-1:0] pop_tos [5] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_tos", 32'(tos), 32'h0);
        chk("rst_nos", 32'(nos), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'h0);
        chk("rst_err", 32'({err_overflow, err_underflow}), 32'h0);
        rst = 1'b0;

        // Two pushes stay entirely in registers.
        issue(PUSH, 8'h11);
        issue(PUSH, 8'h22);
        chk("p2_tos", 32'(tos), 32'h22);
        chk("p2_nos", 32'(nos), 32'h11);
        chk("p2_count", 32'(count), 32'h2);

        // Fill to capacity, then overflow.
        do_reset();
        for (int i = 1; i <= 6; i++) issue(PUSH, DW'(8'h11 * i));
        chk("full_tos", 32'(tos), 32'h66);
        chk("full_nos", 32'(nos), 32'h55);
        chk("full_count", 32'(count), 32'h6);
        for (int k = 0; k < 4; k++) chk("full_slot", 32'(mem[k]), 32'(8'h11 * (k + 1)));
        issue(PUSH, 8'h77);
        chk("ovf_pulse", 32'(err_overflow), 32'h1);
        chk("ovf_tos", 32'(tos), 32'h66);
        chk("ovf_count", 32'(count), 32'h6);
        @(posedge clk); #1;
        chk("ovf_clear", 32'(err_overflow), 32'h0);

        // Pop from full: two stall cycles, then refilled NOS.
        issue(POP, 8'h00);
        chk("pop_stall1", 32'(cmd_ready), 32'h0);
        chk("pop_tos", 32'(tos), 32'h55);
        @(posedge clk); #1;
        chk("pop_stall2", 32'(cmd_ready), 32'h0);
        @(posedge clk); #1;
        chk("pop_ready", 32'(cmd_ready), 32'h1);
        chk("pop_nos", 32'(nos), 32'h44);
        chk("pop_count", 32'(count), 32'h5);
        for (int i = 0; i < 5; i++) begin
            issue(POP, 8'h00);
            wait_idle();
            chk("drain_tos", 32'(tos), 32'(pop_tos[i]));
        end
        issue(POP, 8'h00);
        chk("unf_pulse", 32'(err_underflow), 32'h1);
        chk("unf_count", 32'(count), 32'h0);

        // REPLACE2 with refill.
        do_reset();
        issue(PUSH, 8'h05);
        issue(PUSH, 8'h07);
        issue(PUSH, 8'h09);
        issue(REP2, 8'h10);
        chk("rep_stall", 32'(cmd_ready), 32'h0);
        wait_idle();
        chk("rep_tos", 32'(tos), 32'h10);
        chk("rep_nos", 32'(nos), 32'h05);
        chk("rep_count", 32'(count), 32'h2);

        // REPLACE2 boundaries: rejected at count 1, no stall at count 2.
        do_reset();
        issue(PUSH, 8'hAA);
        issue(REP2, 8'h55);
        chk("rep1_unf", 32'(err_underflow), 32'h1);
        chk("rep1_tos", 32'(tos), 32'hAA);
        issue(PUSH, 8'hBB);
        issue(REP2, 8'h3C);
        chk("rep2_nostall", 32'(cmd_ready), 32'h1);
        chk("rep2_tos", 32'(tos), 32'h3C);
        chk("rep2_nos", 32'(nos), 32'h0);
        chk("rep2_count", 32'(count), 32'h1);

        // Reset while waiting on a refill.
        do_reset();
        issue(PUSH, 8'h01);
        issue(PUSH, 8'h02);
        issue(PUSH, 8'h03);
        issue(POP, 8'h00);
        chk("wait1_busy", 32'(cmd_ready), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_count", 32'(count), 32'h0);
        chk("abort_tos", 32'(tos), 32'h0);
        chk("abort_nos", 32'(nos), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
